mc_core_param: RTL

- Parametrised multicycle processor core: datapath plus integrated control FSM. It is the successor to the fixed 32-bit multicycle datapath that relied on an external controller and an internal RAM.
- Generalised in data width and reset vector.
- Talks to an external word memory through a req/ready handshake, so wait states are supported.
- Executes a MIPS-style 32-bit instruction subset.
- Exposes halt/illegal status for the system top.

---
 rtl/mc_core_param.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mc_core_param.sv
// mc_core_param: parametrised MIPS-subset multicycle core with integrated control FSM and req/ready memory port.
module mc_core_param #(
    parameter int              XLEN     = 32,
    parameter int              ADDR_W   = 16,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ready,
    output logic [XLEN-1:0]   pc,
    output logic [2:0]        state,
    output logic              halt,
    output logic              illegal
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_J = 6'h02, OP_HALT = 6'h3F;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

    state_t            state_q, state_n;
    logic [31:0]       ir;
    logic [XLEN-1:0]   pc_q, a, b, alu_out, mdr, target;
    logic [XLEN-1:0]   regs [32];
    logic              illegal_q;

    logic [5:0]        opcode, funct;
    logic [4:0]        rs, rt, rd, wb_dst;
    logic [XLEN-1:0]   sext_imm, alu_r, exec_res, wb_val;
    logic              funct_ok, op_ok;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign sext_imm = {{(XLEN-16){ir[15]}}, ir[15:0]};

    assign funct_ok = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
    assign op_ok    = (opcode == OP_R) ? funct_ok
                    : opcode inside {OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_HALT};

    always_comb begin
        alu_r = (funct == F_SUB) ? a - b
              : (funct == F_AND) ? a & b
              : (funct == F_OR)  ? a | b
              : (funct == F_SLT) ? XLEN'($signed(a) < $signed(b))
              : a + b;
    end

    assign exec_res = (opcode == OP_R) ? alu_r : a + sext_imm;
    assign wb_dst   = (opcode == OP_R) ? rd : rt;
    assign wb_val   = (opcode == OP_LW) ? mdr : alu_out;

    // The bus request is gated by reset so an in-flight access is dropped the moment reset asserts.
    assign mem_req   = reset & ((state_q == FETCH) | (state_q == MEM));
    assign mem_we    = mem_req & (state_q == MEM) & (opcode == OP_SW);
    assign mem_addr  = ADDR_W'(((state_q == MEM) ? alu_out : pc_q) >> 2);
    assign mem_wdata = b;
    assign pc        = pc_q;
    assign state     = state_q;
    assign halt      = (state_q == HALT);
    assign illegal   = illegal_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            FETCH:   state_n = mem_ready ? DECODE : FETCH;
            DECODE:  state_n = op_ok ? EXEC : HALT;
            EXEC:    state_n = (opcode == OP_R || opcode == OP_ADDI) ? WB
                             : (opcode == OP_LW || opcode == OP_SW)  ? MEM
                             : (opcode == OP_HALT)                   ? HALT
                             : FETCH;
            MEM:     state_n = !mem_ready ? MEM : (opcode == OP_LW) ? WB : FETCH;
            WB:      state_n = FETCH;
            default: state_n = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= RESET_PC;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            target    <= '0;
            illegal_q <= 1'b0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            if (state_q == FETCH && mem_ready) begin
                ir   <= mem_rdata[31:0];
                pc_q <= pc_q + XLEN'(4);
            end
            if (state_q == DECODE) begin
                a      <= regs[rs];
                b      <= regs[rt];
                target <= pc_q + (sext_imm << 2);
                if (!op_ok) illegal_q <= 1'b1;
            end
            if (state_q == EXEC) begin
                alu_out <= exec_res;
                if (opcode == OP_BEQ && a == b) pc_q <= target;
                if (opcode == OP_J) pc_q <= {pc_q[XLEN-1:28], ir[25:0], 2'b00};
            end
            if (state_q == MEM && mem_ready && opcode == OP_LW) mdr <= mem_rdata;
            // R0 is never written, so its reset value keeps it reading as zero.
            if (state_q == WB && wb_dst != 5'd0) regs[wb_dst] <= wb_val;
        end
    end
endmodule
